// File: rtl/data_ram_init.sv
// Single-port data memory with registered read, gated write, and a hardware
// clearing sweep after Reset or on Init so the control unit can stall on Busy.
module data_ram_init #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 4,
  parameter int unsigned       DEPTH       = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Init,
  input  logic              We,
  input  logic              Re,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err,
  output logic              Busy
);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W still fits in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_ptr, init_ptr_next;
  logic [DATA_W-1:0] data_out_next;
  logic              rd_valid_next, err_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_range;

  assign in_range = ({1'b0, Addr} < DEPTH_EXT);
  assign Busy     = (state == ST_INIT);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    data_out_next = data_out;
    rd_valid_next = 1'b0;
    err_next      = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = Addr;
    mem_wdata     = data_in;

    unique case (state)
      ST_INIT: begin
        if (Init) begin
          init_ptr_next = '0;
        end else begin
          mem_we        = 1'b1;
          mem_waddr     = init_ptr;
          mem_wdata     = RESET_VALUE;
          init_ptr_next = init_ptr + 1'b1;
          if (init_ptr == LAST_PTR) begin
            state_next    = ST_IDLE;
            init_ptr_next = '0;
          end
        end
      end

      ST_IDLE: begin
        if (Init) begin
          state_next    = ST_INIT;
          init_ptr_next = '0;
        end else if (in_range) begin
          mem_we = We;
          if (Re) begin
            rd_valid_next = 1'b1;
            // Write-first: a same-cycle write is what the read returns.
            data_out_next = We ? data_in : mem[Addr];
          end
        end else begin
          err_next = We | Re;
          if (Re) begin
            rd_valid_next = 1'b1;
            data_out_next = RESET_VALUE;
          end
        end
      end

      default: state_next = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      data_out <= RESET_VALUE;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
      data_out <= data_out_next;
      rd_valid <= rd_valid_next;
      err      <= err_next;
    end
  end

  // NOTE: the array has no reset term; it is cleared by the init sweep so it
  // can map onto real RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_ram_init.sv
// Directed table-driven bench for data_ram_init: a default 16-entry instance and
// a 12-entry instance (RESET_VALUE 8'hFF) for out-of-range behaviour.
module tb_data_ram_init;

  logic       Clk;
  logic       reset_a, init_a, we_a, re_a;
  logic [3:0] addr_a;
  logic [7:0] din_a, dout_a;
  logic       rv_a, err_a, busy_a;

  logic       reset_b, init_b, we_b, re_b;
  logic [3:0] addr_b;
  logic [7:0] din_b, dout_b;
  logic       rv_b, err_b, busy_b;

  int checks   = 0;
  int failures = 0;

  data_ram_init u_dut_a (
    .Clk(Clk), .Reset(reset_a), .Init(init_a), .We(we_a), .Re(re_a),
    .Addr(addr_a), .data_in(din_a), .data_out(dout_a),
    .rd_valid(rv_a), .err(err_a), .Busy(busy_a)
  );

  data_ram_init #(.DEPTH(12), .RESET_VALUE(8'hFF)) u_dut_b (
    .Clk(Clk), .Reset(reset_b), .Init(init_b), .We(we_b), .Re(re_b),
    .Addr(addr_b), .data_in(din_b), .data_out(dout_b),
    .rd_valid(rv_b), .err(err_b), .Busy(busy_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       sel;
    logic       init;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic sel, input logic [7:0] dout,
                            input logic valid, input logic e, input logic busy);
    if (sel == 1'b0) begin
      check({name, ".dout"}, dout_a, dout);
      check({name, ".valid"}, {7'd0, rv_a}, {7'd0, valid});
      check({name, ".err"}, {7'd0, err_a}, {7'd0, e});
      check({name, ".busy"}, {7'd0, busy_a}, {7'd0, busy});
    end else begin
      check({name, ".dout"}, dout_b, dout);
      check({name, ".valid"}, {7'd0, rv_b}, {7'd0, valid});
      check({name, ".err"}, {7'd0, err_b}, {7'd0, e});
      check({name, ".busy"}, {7'd0, busy_b}, {7'd0, busy});
    end
  endtask

  task automatic drive(input logic sel, input logic init, input logic we, input logic re,
                       input logic [3:0] addr, input logic [7:0] din);
    init_a = 1'b0; we_a = 1'b0; re_a = 1'b0; addr_a = 4'd0; din_a = 8'd0;
    init_b = 1'b0; we_b = 1'b0; re_b = 1'b0; addr_b = 4'd0; din_b = 8'd0;
    if (sel == 1'b0) begin
      init_a = init; we_a = we; re_a = re; addr_a = addr; din_a = din;
    end else begin
      init_b = init; we_b = we; re_b = re; addr_b = addr; din_b = din;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Count edges until Busy drops; bounded so a stuck sweep cannot hang the run.
  task automatic count_sweep(input logic sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((sel == 1'b0) ? busy_a : busy_b) && n < 64);
  endtask

  task automatic add(input logic sel, input logic init, input logic we, input logic re,
                     input logic [3:0] addr, input logic [7:0] din, input logic [7:0] dout,
                     input logic valid, input logic e, input logic busy);
    vec_t v;
    v = '{sel, init, we, re, addr, din, dout, valid, e, busy};
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].init, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din);
      tick();
      check_outs($sformatf("%s[%0d]", name, i), vecs[i].sel, vecs[i].dout,
                 vecs[i].valid, vecs[i].err, vecs[i].busy);
    end
    vecs.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  initial begin
    int n;

    reset_a = 1'b1;
    reset_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    tick();
    check_outs("reset_a", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_outs("reset_b", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);

    // Release both; the 12-entry sweep ends 4 edges before the 16-entry one.
    reset_a = 1'b0;
    reset_b = 1'b0;
    count_sweep(1'b1, n);
    check("sweep_b_edges", 8'(n), 8'd12);
    count_sweep(1'b0, n);
    check("sweep_a_edges", 8'(n + 12), 8'd16);

    // Every entry reads back as zero, back-to-back, one-cycle latency.
    for (int i = 0; i < 16; i++)
      add(1'b0, 0, 0, 1, 4'(i), 8'h00, 8'h00, 1, 0, 0);
    add(1'b0, 0, 1, 0, 4'd3,  8'hA5, 8'h00, 0, 0, 0);
    add(1'b0, 0, 0, 1, 4'd3,  8'h00, 8'hA5, 1, 0, 0);
    add(1'b0, 0, 0, 0, 4'd3,  8'h00, 8'hA5, 0, 0, 0);
    add(1'b0, 0, 1, 0, 4'd7,  8'h11, 8'hA5, 0, 0, 0);
    add(1'b0, 0, 1, 1, 4'd7,  8'h3C, 8'h3C, 1, 0, 0);
    add(1'b0, 0, 0, 0, 4'd7,  8'h00, 8'h3C, 0, 0, 0);
    add(1'b0, 0, 0, 1, 4'd3,  8'h00, 8'hA5, 1, 0, 0);
    add(1'b0, 0, 0, 1, 4'd7,  8'h00, 8'h3C, 1, 0, 0);
    add(1'b0, 0, 1, 0, 4'd0,  8'hDE, 8'h3C, 0, 0, 0);
    add(1'b0, 0, 1, 0, 4'd15, 8'hBE, 8'h3C, 0, 0, 0);
    add(1'b0, 0, 1, 0, 4'd2,  8'h77, 8'h3C, 0, 0, 0);
    add(1'b0, 0, 0, 1, 4'd0,  8'h00, 8'hDE, 1, 0, 0);
    add(1'b0, 0, 0, 1, 4'd15, 8'h00, 8'hBE, 1, 0, 0);
    add(1'b0, 0, 0, 1, 4'd2,  8'h00, 8'h77, 1, 0, 0);
    run_vecs("rw_a");

    // Out-of-range behaviour on the 12-entry instance.
    add(1'b1, 0, 1, 0, 4'd11, 8'h22, 8'hFF, 0, 0, 0);
    add(1'b1, 0, 0, 1, 4'd11, 8'h00, 8'h22, 1, 0, 0);
    add(1'b1, 0, 1, 0, 4'd13, 8'h55, 8'h22, 0, 1, 0);
    add(1'b1, 0, 0, 0, 4'd13, 8'h00, 8'h22, 0, 0, 0);
    add(1'b1, 0, 0, 1, 4'd13, 8'h00, 8'hFF, 1, 1, 0);
    add(1'b1, 0, 0, 1, 4'd11, 8'h00, 8'h22, 1, 0, 0);
    add(1'b1, 0, 1, 1, 4'd12, 8'h66, 8'hFF, 1, 1, 0);
    add(1'b1, 0, 0, 1, 4'd1,  8'h00, 8'hFF, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd5,  8'h00, 8'hFF, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd9,  8'h00, 8'hFF, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd0,  8'h00, 8'hFF, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd4,  8'h00, 8'hFF, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd15, 8'h00, 8'hFF, 1, 1, 0);
    run_vecs("oor_b");

    // Init with a same-cycle write: write dropped, 16-edge sweep, all entries zero.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h99);
    tick();
    check_outs("init_edge", 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    // Accesses during the sweep are ignored and data_out holds.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h44);
    n = 0;
    do begin
      tick();
      n++;
      if (rv_a !== 1'b0 || err_a !== 1'b0 || dout_a !== 8'h77)
        check_outs($sformatf("sweep_quiet[%0d]", n), 1'b0, 8'h77, 1'b0, 1'b0, busy_a);
    end while (busy_a && n < 64);
    check("init_sweep_edges", 8'(n), 8'd16);
    check("sweep_dout_hold", dout_a, 8'h77);
    for (int i = 0; i < 16; i++)
      add(1'b0, 0, 0, 1, 4'(i), 8'h00, 8'h00, 1, 0, 0);
    run_vecs("clear_a");

    // Init during the sweep restarts it from entry 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    count_sweep(1'b0, n);
    check("restart_sweep_edges", 8'(n), 8'd16);

    // Reset at init_ptr = 9 after a nonzero read.
    add(1'b0, 0, 1, 0, 4'd4, 8'h5A, 8'h00, 0, 0, 0);
    add(1'b0, 0, 0, 1, 4'd4, 8'h00, 8'h5A, 1, 0, 0);
    run_vecs("pre_reset");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    check("mid_sweep_busy", {7'd0, busy_a}, 8'd1);
    check("mid_sweep_dout", dout_a, 8'h5A);
    reset_a = 1'b1;
    #1;
    check_outs("reset_mid_sweep", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #2;
    reset_a = 1'b0;
    count_sweep(1'b0, n);
    check("reset_sweep_edges", 8'(n), 8'd16);

    // Reset one cycle after a read request clears rd_valid asynchronously.
    add(1'b0, 0, 1, 0, 4'd4, 8'h5A, 8'h00, 0, 0, 0);
    add(1'b0, 0, 0, 1, 4'd4, 8'h00, 8'h5A, 1, 0, 0);
    run_vecs("pre_reset2");
    reset_a = 1'b1;
    #1;
    check_outs("reset_mid_read", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset while err is high on the 12-entry instance.
    add(1'b1, 0, 0, 1, 4'd11, 8'h00, 8'h22, 1, 0, 0);
    add(1'b1, 0, 0, 1, 4'd14, 8'h00, 8'hFF, 1, 1, 0);
    run_vecs("pre_reset_b");
    reset_b = 1'b1;
    #1;
    check_outs("reset_mid_err", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    #2;
    reset_a = 1'b0;
    reset_b = 1'b0;
    count_sweep(1'b1, n);
    check("reset_b_sweep_edges", 8'(n), 8'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
